// File: rtl/wave_ctrl.sv
// Wave sequencer: spawns a formation, tracks per-enemy hits, advances levels.
// Optional formation march is enabled by defining WAVE_MARCH_EN.
module wave_ctrl #(
  parameter int NUM_EN       = 3,
  parameter int SPAWN_FRAMES = 60,
  parameter int MARCH_MAX    = 200
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic              start,
  input  logic [NUM_EN-1:0] hit,
  output logic [NUM_EN-1:0] alive,
  output logic [4:0]        level,
  output logic [9:0]        x_offset,
  output logic              wave_clear,
  output logic              spawning
);

  localparam int CNT_W = $clog2(SPAWN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SPAWN, PLAY, CLEAR} state_t;

  state_t            state, state_nxt;
  logic              vsync_q;
  logic              tick;
  logic              spawn_done;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_EN-1:0] alive_nxt, alive_hit;
  logic [4:0]        level_nxt;
  logic              wave_clear_nxt;

  function automatic logic [4:0] level_inc(input logic [4:0] lv);
    return (lv == 5'd31) ? lv : lv + 5'd1;
  endfunction

  // vsync_q resets high so a vsync already high at reset release is not a tick
  assign tick       = vsync_in & ~vsync_q;
  assign spawn_done = tick && (cnt == CNT_W'(SPAWN_FRAMES - 1));
  assign alive_hit  = alive & ~hit;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = SPAWN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SPAWN:   if (spawn_done) state_nxt = PLAY;
        PLAY:    if (alive_hit == '0) state_nxt = CLEAR;
        CLEAR:   state_nxt = SPAWN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    alive_nxt      = alive;
    level_nxt      = level;
    cnt_nxt        = cnt;
    wave_clear_nxt = 1'b0;
    if (start) begin
      alive_nxt = '0;
      level_nxt = 5'd1;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE:  alive_nxt = '0;
        SPAWN: begin
          if (tick) cnt_nxt = cnt + CNT_W'(1);
          if (spawn_done) alive_nxt = '1;
        end
        PLAY:  alive_nxt = alive_hit;
        CLEAR: begin
          wave_clear_nxt = 1'b1;
          level_nxt      = level_inc(level);
          cnt_nxt        = '0;
        end
        default: alive_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b1;
      cnt        <= '0;
      alive      <= '0;
      level      <= 5'd1;
      wave_clear <= 1'b0;
      spawning   <= 1'b0;
    end else begin
      vsync_q    <= vsync_in;
      cnt        <= cnt_nxt;
      alive      <= alive_nxt;
      level      <= level_nxt;
      wave_clear <= wave_clear_nxt;
      spawning   <= (state_nxt == SPAWN);
    end
  end

`ifdef WAVE_MARCH_EN
  localparam logic signed [11:0] MARCH_MAX_S = 12'(MARCH_MAX);

  logic               dir_left, dir_left_nxt;
  logic [9:0]         x_nxt;
  logic [3:0]         step;
  logic signed [11:0] x_cur_s, step_s, x_try;

  function automatic logic [9:0] march_clamp(input logic signed [11:0] pos);
    if (pos > MARCH_MAX_S) return 10'(MARCH_MAX);
    if (pos < 12'sd0)      return 10'd0;
    return pos[9:0];
  endfunction

  // Formation restarts at the left edge, heading right, whenever a spawn begins
  always_comb begin
    step         = 4'd1 + {1'b0, level[4:2]};
    x_cur_s      = {2'b00, x_offset};
    step_s       = {8'd0, step};
    x_try        = dir_left ? (x_cur_s - step_s) : (x_cur_s + step_s);
    x_nxt        = x_offset;
    dir_left_nxt = dir_left;
    if (start || (state_nxt == SPAWN && state != SPAWN)) begin
      x_nxt        = '0;
      dir_left_nxt = 1'b0;
    end else if (state == PLAY && tick) begin
      x_nxt = march_clamp(x_try);
      if (x_try > MARCH_MAX_S)  dir_left_nxt = 1'b1;
      else if (x_try < 12'sd0)  dir_left_nxt = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x_offset <= '0;
      dir_left <= 1'b0;
    end else begin
      x_offset <= x_nxt;
      dir_left <= dir_left_nxt;
    end
  end
`else
  assign x_offset = '0;
`endif

endmodule

// File: tb/tb_wave_ctrl.sv
// Randomized bench for wave_ctrl against an integer-level behavioural model.
module tb_wave_ctrl;

  localparam int NUM_EN       = 3;
  localparam int SPAWN_FRAMES = 60;
  localparam int MARCH_MAX    = 200;
  localparam int ALL          = (1 << NUM_EN) - 1;
  localparam int P_IDLE = 0, P_SPAWN = 1, P_PLAY = 2, P_CLEAR = 3;

  logic              pclk = 1'b0;
  logic              rst, vsync_in, start;
  logic [NUM_EN-1:0] hit;
  logic [NUM_EN-1:0] alive;
  logic [4:0]        level;
  logic [9:0]        x_offset;
  logic              wave_clear, spawning;

  wave_ctrl #(
    .NUM_EN(NUM_EN), .SPAWN_FRAMES(SPAWN_FRAMES), .MARCH_MAX(MARCH_MAX)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start), .hit(hit),
    .alive(alive), .level(level), .x_offset(x_offset),
    .wave_clear(wave_clear), .spawning(spawning)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int m_phase, m_frames, m_alive, m_level, m_x, m_dir, m_wc;
  bit m_vs_prev;
  int vs_phase = 0, vs_period = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_frames = 0; m_alive = 0; m_level = 1;
    m_x = 0; m_dir = 1; m_wc = 0; m_vs_prev = 1'b1;
  endtask

  task automatic model_edge(input bit st, input int h, input bit vs);
    bit tk;
    tk = vs && !m_vs_prev;
    m_vs_prev = vs;
    m_wc = 0;
    if (st) begin
      m_phase = P_SPAWN; m_level = 1; m_alive = 0; m_frames = 0; m_x = 0; m_dir = 1;
    end else if (m_phase == P_IDLE) begin
      m_alive = 0;
    end else if (m_phase == P_SPAWN) begin
      if (tk) begin
        m_frames++;
        if (m_frames == SPAWN_FRAMES) begin
          m_phase = P_PLAY;
          m_alive = ALL;
        end
      end
    end else if (m_phase == P_PLAY) begin
`ifdef WAVE_MARCH_EN
      if (tk) begin
        int nx;
        nx = m_x + m_dir * (1 + m_level / 4);
        if (nx > MARCH_MAX) begin nx = MARCH_MAX; m_dir = -1; end
        else if (nx < 0)    begin nx = 0;         m_dir = 1;  end
        m_x = nx;
      end
`endif
      m_alive = m_alive & ~h & ALL;
      if (m_alive == 0) m_phase = P_CLEAR;
    end else begin
      m_wc = 1;
      m_level = (m_level < 31) ? m_level + 1 : 31;
      m_frames = 0; m_x = 0; m_dir = 1;
      m_phase = P_SPAWN;
    end
  endtask

  task automatic check_outputs();
    check("alive", alive, m_alive);
    check("level", level, m_level);
    check("x_offset", x_offset, m_x);
    check("wave_clear", wave_clear, m_wc);
    check("spawning", spawning, (m_phase == P_SPAWN) ? 1 : 0);
  endtask

  task automatic step(input bit st, input int h, input bit vs);
    start    = st;
    hit      = h[NUM_EN-1:0];
    vsync_in = vs;
    @(posedge pclk);
    model_edge(st, h, vs);
    #1;
    check_outputs();
  endtask

  task automatic gen_vs(output bit vs);
    vs = (vs_phase == 0);
    vs_phase++;
    if (vs_phase >= vs_period) begin
      vs_phase  = 0;
      vs_period = int'($urandom_range(2, 4));
    end
  endtask

  function automatic int rand_hit(input int prob);
    if (int'($urandom_range(0, 99)) < prob) return int'($urandom_range(1, ALL));
    return 0;
  endfunction

  task automatic wait_phase(input int target, input int hit_prob, input int budget);
    int n;
    bit vs;
    n = 0;
    while (m_phase != target && n < budget) begin
      gen_vs(vs);
      step(1'b0, rand_hit(hit_prob), vs);
      n++;
    end
    if (n >= budget) check("wait_timeout", m_phase, target);
  endtask

  task automatic run_wave(input int spawn_prob, input int play_prob);
    bit vs;
    wait_phase(P_PLAY, spawn_prob, 2000);
    wait_phase(P_CLEAR, play_prob, 5000);
    gen_vs(vs);
    step(1'b0, rand_hit(50), vs);
  endtask

  initial begin
    bit vs, st;
    int guard;
    rst = 1'b1; start = 1'b0; hit = '0; vsync_in = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge pclk); #1;
      check_outputs();
    end
    rst = 1'b0;

    // idle: hits and frames do nothing
    repeat (12) begin gen_vs(vs); step(1'b0, rand_hit(50), vs); end

    // first wave: spawn, then hit 010 and 101
    step(1'b1, 0, 1'b0);
    wait_phase(P_PLAY, 40, 2000);
    step(1'b0, 3'b010, 1'b0);
    step(1'b0, 3'b101, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // repeated hit on a dead enemy
    wait_phase(P_PLAY, 50, 2000);
    step(1'b0, 3'b001, 1'b0);
    step(1'b0, 3'b001, 1'b1);
    step(1'b0, 3'b110, 1'b0);
    step(1'b0, 0, 1'b0);

    // long play with frames only: march bounces off the right edge
    wait_phase(P_PLAY, 0, 2000);
    repeat (900) begin gen_vs(vs); step(1'b0, 0, vs); end
    step(1'b0, 3'b111, 1'b0);
    step(1'b0, 0, 1'b0);

    // climb to the level cap and clear past it
    guard = 0;
    while (m_level < 31 && guard < 60) begin run_wave(30, 4); guard++; end
    run_wave(30, 4);
    run_wave(30, 4);

    // restart with a simultaneous hit and frame
    wait_phase(P_PLAY, 20, 2000);
    repeat (5) begin gen_vs(vs); step(1'b0, 0, vs); end
    step(1'b1, 3'b011, 1'b1);
    step(1'b0, 3'b111, 1'b0);

    // asynchronous reset while the clear is pending
    wait_phase(P_PLAY, 20, 2000);
    step(1'b0, 3'b111, 1'b0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(posedge pclk); #1;
    check_outputs();
    rst = 1'b0;
    repeat (6) begin gen_vs(vs); step(1'b0, rand_hit(40), vs); end

    // random soak with occasional restarts
    step(1'b1, 0, 1'b0);
    repeat (4000) begin
      gen_vs(vs);
      st = ($urandom_range(0, 299) == 0);
      step(st, rand_hit(8), vs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
